alu_share_arb: RTL and testbench

- Shares one 32-bit ALU datapath between two requesters. The datapath supports add, sub, logic ops and signed/unsigned set-less-than.
- Round-robin arbitration with valid/ready handshakes on both the request and response sides.
- The result is registered in a single result slot and held until the owning requester drains it.
- Sits between two client engines (e.g. an address unit and a compare unit) and the ALU, so only one ALU instance is needed.

---
 rtl/alu_share_arb_if.sv | 40 ++++
 rtl/alu_share_arb.sv | 116 +++++++++++
 tb/tb_alu_share_arb.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arb_if.sv
// Request/response bundle between two ALU clients and the shared ALU.
// The master side belongs to the clients; the ALU arbiter is the slave.
interface alu_share_arb_if #(
   parameter int WIDTH = 32
);
   logic             req0_valid;
   logic             req0_ready;
   logic [2:0]       req0_op;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic             req1_valid;
   logic             req1_ready;
   logic [2:0]       req1_op;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic             rsp0_valid;
   logic             rsp0_ready;
   logic             rsp1_valid;
   logic             rsp1_ready;
   logic [WIDTH-1:0] rsp_result;
   logic             rsp_overflow;

   modport master (
      output req0_valid, req0_op, req0_a, req0_b,
      output req1_valid, req1_op, req1_a, req1_b,
      output rsp0_ready, rsp1_ready,
      input  req0_ready, req1_ready,
      input  rsp0_valid, rsp1_valid,
      input  rsp_result, rsp_overflow
   );

   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b,
      input  req1_valid, req1_op, req1_a, req1_b,
      input  rsp0_ready, rsp1_ready,
      output req0_ready, req1_ready,
      output rsp0_valid, rsp1_valid,
      output rsp_result, rsp_overflow
   );
endinterface

// File: rtl/alu_share_arb.sv
// One ALU shared by two requesters: round-robin grant, single result
// slot that is held until its owner drains it.
module alu_share_arb #(
   parameter int WIDTH = 32
) (
   input logic            clk,
   input logic            rst_n,
   alu_share_arb_if.slave bus
);
   localparam int MSB = WIDTH - 1;

   typedef enum logic {IDLE, HOLD} state_t;

   state_t           state;
   state_t           state_n;
   logic             owner;
   logic             last_grant;
   logic [WIDTH-1:0] result;
   logic             ovf;

   logic             sel;
   logic             drain;
   logic             slot_free;
   logic             rdy0;
   logic             rdy1;
   logic             accept;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] sum;
   logic [WIDTH:0]   diff;
   logic             ovf_add;
   logic             ovf_sub;
   logic [WIDTH-1:0] res_d;
   logic             ovf_d;

   always_comb begin
      drain     = owner ? bus.rsp1_ready : bus.rsp0_ready;
      slot_free = (state == IDLE) || drain;
      sel       = 1'b0;
      if (bus.req0_valid && bus.req1_valid)
         sel = ~last_grant;
      else if (bus.req1_valid)
         sel = 1'b1;
      // ready is forced low while reset is held
      rdy0   = rst_n & slot_free & ~sel;
      rdy1   = rst_n & slot_free & sel;
      accept = sel ? (bus.req1_valid & rdy1)
                   : (bus.req0_valid & rdy0);
   end

   always_comb begin
      op = sel ? bus.req1_op : bus.req0_op;
      a  = sel ? bus.req1_a  : bus.req0_a;
      b  = sel ? bus.req1_b  : bus.req0_b;
   end

   always_comb begin
      sum     = a + b;
      diff    = {1'b0, a} - {1'b0, b};
      ovf_add = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      ovf_sub = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      res_d   = '0;
      ovf_d   = 1'b0;
      unique case (op)
         3'b000: begin
            res_d = sum;
            ovf_d = ovf_add;
         end
         3'b001: begin
            res_d = diff[MSB:0];
            ovf_d = ovf_sub;
         end
         3'b010: res_d = a & b;
         3'b011: res_d = a | b;
         3'b100: res_d = a ^ b;
         3'b101: res_d = ~(a | b);
         3'b110: res_d = {{(WIDTH-1){1'b0}}, diff[MSB] ^ ovf_sub};
         3'b111: res_d = {{(WIDTH-1){1'b0}}, diff[WIDTH]};
         default: res_d = '0;
      endcase
   end

   always_comb begin
      state_n = state;
      if (accept)
         state_n = HOLD;
      else if (state == HOLD && drain)
         state_n = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         result     <= '0;
         ovf        <= 1'b0;
      end else begin
         state <= state_n;
         if (accept) begin
            owner      <= sel;
            last_grant <= sel;
            result     <= res_d;
            ovf        <= ovf_d;
         end
      end
   end

   assign bus.req0_ready   = rdy0;
   assign bus.req1_ready   = rdy1;
   assign bus.rsp0_valid   = (state == HOLD) && !owner;
   assign bus.rsp1_valid   = (state == HOLD) && owner;
   assign bus.rsp_result   = result;
   assign bus.rsp_overflow = ovf;
endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with a queue scoreboard
// and an independent response monitor.
module tb_alu_share_arb;
   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   alu_share_arb_if #(.WIDTH(32)) bus ();

   alu_share_arb #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic        who;
      logic [31:0] res;
      logic        ovf;
   } exp_t;

   exp_t sb[$];
   int   nchk = 0;
   int   nfail = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   // monitor: pop and compare on every response handshake
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if ((bus.rsp0_valid && bus.rsp0_ready) ||
             (bus.rsp1_valid && bus.rsp1_ready)) begin
            if (sb.size() == 0) begin
               nchk++;
               nfail++;
               $display("FAIL sb_empty: got result %h expected none",
                        bus.rsp_result);
            end else begin
               e = sb.pop_front();
               chk("rsp_owner", {31'b0, bus.rsp1_valid}, {31'b0, e.who});
               chk("rsp_result", bus.rsp_result, e.res);
               chk("rsp_overflow", {31'b0, bus.rsp_overflow},
                   {31'b0, e.ovf});
            end
         end
      end
   end

   task automatic issue(input logic who, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic ovf);
      logic mine;
      logic other;
      if (who) begin
         bus.req1_valid = 1'b1;
         bus.req1_op    = op;
         bus.req1_a     = a;
         bus.req1_b     = b;
      end else begin
         bus.req0_valid = 1'b1;
         bus.req0_op    = op;
         bus.req0_a     = a;
         bus.req0_b     = b;
      end
      @(negedge clk);
      mine  = who ? bus.req1_ready : bus.req0_ready;
      other = who ? bus.req0_ready : bus.req1_ready;
      chk(who ? "req1_ready" : "req0_ready", {31'b0, mine}, 32'd1);
      chk("other_ready", {31'b0, other}, 32'd0);
      if (mine)
         sb.push_back('{who: who, res: res, ovf: ovf});
      sync();
      if (who)
         bus.req1_valid = 1'b0;
      else
         bus.req0_valid = 1'b0;
   endtask

   initial begin
      logic g;
      bus.req0_valid = 1'b1;
      bus.req0_op    = '0;
      bus.req0_a     = '0;
      bus.req0_b     = '0;
      bus.req1_valid = 1'b0;
      bus.req1_op    = '0;
      bus.req1_a     = '0;
      bus.req1_b     = '0;
      bus.rsp0_ready = 1'b1;
      bus.rsp1_ready = 1'b1;

      // reset state, ready gated while rst_n low
      @(negedge clk);
      chk("rst_req0_ready", {31'b0, bus.req0_ready}, 32'd0);
      chk("rst_rsp0_valid", {31'b0, bus.rsp0_valid}, 32'd0);
      chk("rst_rsp1_valid", {31'b0, bus.rsp1_valid}, 32'd0);
      chk("rst_result", bus.rsp_result, 32'd0);
      chk("rst_overflow", {31'b0, bus.rsp_overflow}, 32'd0);
      bus.req0_valid = 1'b0;
      sync();
      rst_n = 1'b1;
      sync();

      issue(1'b0, 3'b001, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0);
      @(negedge clk);
      chk("lat_rsp0_valid", {31'b0, bus.rsp0_valid}, 32'd1);
      chk("lat_rsp1_valid", {31'b0, bus.rsp1_valid}, 32'd0);
      sync();

      issue(1'b0, 3'b000, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b1);
      issue(1'b0, 3'b110, 32'h8000_0000, 32'd1, 32'd1, 1'b0);
      issue(1'b1, 3'b001, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b1);
      issue(1'b0, 3'b001, 32'h7FFF_FFFF, 32'hFFFF_FFFF,
            32'h8000_0000, 1'b1);
      issue(1'b1, 3'b000, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
      issue(1'b0, 3'b011, 32'h0F0F_0000, 32'h0000_00FF,
            32'h0F0F_00FF, 1'b0);
      issue(1'b1, 3'b100, 32'hFFFF_0000, 32'h0F0F_0F0F,
            32'hF0F0_0F0F, 1'b0);
      issue(1'b0, 3'b101, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0);
      issue(1'b0, 3'b111, 32'd1, 32'hFFFF_FFFF, 32'd1, 1'b0);
      issue(1'b1, 3'b010, 32'hF0F0_F0F0, 32'hFF00_FF00,
            32'hF000_F000, 1'b0);

      // tie: last grant was requester 1, so 0 goes first
      bus.req0_valid = 1'b1;
      bus.req0_op    = 3'b110;
      bus.req0_a     = 32'hFFFF_FFFF;
      bus.req0_b     = 32'd1;
      bus.req1_valid = 1'b1;
      bus.req1_op    = 3'b111;
      bus.req1_a     = 32'hFFFF_FFFF;
      bus.req1_b     = 32'd1;
      g = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("tie_req0_ready", {31'b0, bus.req0_ready}, {31'b0, ~g});
         chk("tie_req1_ready", {31'b0, bus.req1_ready}, {31'b0, g});
         if (bus.req0_ready || bus.req1_ready)
            sb.push_back('{who: g, res: {31'b0, ~g}, ovf: 1'b0});
         sync();
         g = ~g;
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      sync();

      // frozen slot blocks the other requester
      bus.rsp0_ready = 1'b0;
      issue(1'b0, 3'b000, 32'd1, 32'd2, 32'd3, 1'b0);
      bus.req1_valid = 1'b1;
      bus.req1_op    = 3'b001;
      bus.req1_a     = 32'd10;
      bus.req1_b     = 32'd3;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("frz_req1_ready", {31'b0, bus.req1_ready}, 32'd0);
         chk("frz_req0_ready", {31'b0, bus.req0_ready}, 32'd0);
         chk("frz_rsp0_valid", {31'b0, bus.rsp0_valid}, 32'd1);
         chk("frz_result", bus.rsp_result, 32'd3);
         sync();
      end
      bus.rsp0_ready = 1'b1;
      @(negedge clk);
      chk("unfrz_req1_ready", {31'b0, bus.req1_ready}, 32'd1);
      if (bus.req1_ready)
         sb.push_back('{who: 1'b1, res: 32'd7, ovf: 1'b0});
      sync();
      bus.req1_valid = 1'b0;
      @(negedge clk);
      chk("unfrz_rsp1_valid", {31'b0, bus.rsp1_valid}, 32'd1);
      sync();

      // asynchronous reset while holding a result
      bus.rsp0_ready = 1'b0;
      issue(1'b0, 3'b000, 32'd5, 32'd7, 32'd12, 1'b0);
      bus.req0_valid = 1'b1;
      bus.req0_op    = 3'b100;
      bus.req0_a     = 32'd3;
      bus.req0_b     = 32'd5;
      bus.req1_valid = 1'b1;
      bus.req1_op    = 3'b000;
      bus.req1_a     = 32'd1;
      bus.req1_b     = 32'd1;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_rsp0_valid", {31'b0, bus.rsp0_valid}, 32'd0);
      chk("arst_rsp1_valid", {31'b0, bus.rsp1_valid}, 32'd0);
      chk("arst_result", bus.rsp_result, 32'd0);
      chk("arst_req0_ready", {31'b0, bus.req0_ready}, 32'd0);
      sb.delete();
      bus.rsp0_ready = 1'b1;
      sync();
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_tie_req0", {31'b0, bus.req0_ready}, 32'd1);
      chk("post_tie_req1", {31'b0, bus.req1_ready}, 32'd0);
      if (bus.req0_ready)
         sb.push_back('{who: 1'b0, res: 32'd6, ovf: 1'b0});
      sync();
      bus.req0_valid = 1'b0;
      @(negedge clk);
      chk("post_req1_ready", {31'b0, bus.req1_ready}, 32'd1);
      if (bus.req1_ready)
         sb.push_back('{who: 1'b1, res: 32'd2, ovf: 1'b0});
      sync();
      bus.req1_valid = 1'b0;

      for (int i = 0; i < 20 && sb.size() != 0; i++)
         sync();
      chk("sb_drained", sb.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               nchk, nfail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
